// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART receive and transmit paths.
package bt_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } bt_uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        LINE_IDLE = 1'b1;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_uart_rx_if.sv
// Byte handshake from the UART receiver to the command logic.
interface bt_uart_rx_if;
  import bt_uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/bt_sync2.sv
// Two-flop synchroniser for an asynchronous input pin.
module bt_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset value matches the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module's TXD line, with valid/ready byte output.
module bt_uart_rx
  import bt_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  bt_uart_rx_if.master        rx_if,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("bt_uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic w_rx_s;

  bt_uart_state_e       r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  bt_sync2 #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  // Receive FSM with registered byte, valid and error-pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (w_rx_s != LINE_IDLE) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          // Half-bit wait puts every later sample at mid-bit.
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (w_rx_s != LINE_IDLE) begin
              r_state   <= StData;
              r_bit_idx <= '0;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == CNT_BIT) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == CNT_BIT) begin
            r_cnt <= '0;
            if (w_rx_s == LINE_IDLE) begin
              // A byte being accepted on this edge frees the slot for the new one.
              if (!r_valid || rx_if.rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StWaitIdle;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitIdle: begin
          // Wait out a break so a held-low line yields one error, not a frame stream.
          if (w_rx_s == LINE_IDLE) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign frame_err      = r_frame_err;
  assign overrun        = r_overrun;
  assign busy           = (r_state != StIdle);

endmodule
